// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, the canonical NOP and fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StFull
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a single-entry
// output register toward decode, and redirect handling with a kill flag for
// responses that are already in flight.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] pc_target
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] redirect_pc;

    // Redirect targets are forced word-aligned.
    assign redirect_pc = {pc_target[XLEN-1:2], 2'b00};

    // Next-state logic, pc update, response capture and the memory request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        imem_req   = 1'b0;

        unique case (state_q)
            StFetch: begin
                // A redirect suppresses this cycle's request; the target goes out next cycle.
                if (PCSrc) begin
                    pc_d = redirect_pc;
                end else begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (PCSrc) begin
                    pc_d = redirect_pc;
                end
                if (imem_rvalid) begin
                    // A response belonging to a redirected-away fetch is dropped.
                    if (kill_q || PCSrc) begin
                        state_d = StFetch;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = StFull;
                    end
                    kill_d = 1'b0;
                end else if (PCSrc) begin
                    kill_d = 1'b1;
                end
            end
            StFull: begin
                // Redirect wins over a simultaneous decode handshake.
                if (PCSrc) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // State, pc, kill flag and output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StFull) && !rst;
    assign instruction = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run with
// a memory model, a program-order reference queue and an independent monitor.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        PCSrc;
    logic [31:0] pc_target;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .instr_pc   (instr_pc),
        .PCSrc      (PCSrc),
        .pc_target  (pc_target)
    );

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q[$];     // architectural pc of the next instruction decode should see

    // Memory model: contents are a bijective function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Zero-wait fetch from FETCH into FULL; optionally consumes it.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data, input bit consume);
        imem_gnt = 1'b1;
        settle();
        check1("fetch_req", imem_req, 1'b1);
        check32("fetch_addr", imem_addr, pc);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        settle();
        check1("wait_valid", instr_valid, 1'b0);
        check1("wait_req", imem_req, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        instr_ready = consume;
        settle();
        check1("full_valid", instr_valid, 1'b1);
        check32("full_instr", instruction, data);
        check32("full_pc", instr_pc, pc);
        check1("full_req", imem_req, 1'b0);
        if (consume) begin
            tick();
            instr_ready = 1'b0;
        end
    endtask

    // Monitor: compares every decode handshake against the reference queue and
    // checks that a held instruction stays put until consumed.
    bit          prev_hold = 1'b0;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                if (prev_hold) begin
                    check1("hold_valid", instr_valid, 1'b1);
                    check32("hold_instr", instruction, prev_instr);
                    check32("hold_pc", instr_pc, prev_pc);
                end
                if (instr_valid) begin
                    check1("no_req_when_full", imem_req, 1'b0);
                end
                if (instr_valid && instr_ready && !PCSrc) begin
                    if (exp_q.size() == 0) begin
                        check1("sb_nonempty", 1'b0, 1'b1);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        check32("sb_pc", instr_pc, e);
                        check32("sb_instr", instruction, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                        delivered++;
                    end
                end
                prev_hold  = instr_valid && !instr_ready && !PCSrc;
                prev_instr = instruction;
                prev_pc    = instr_pc;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    bit          out_valid;
    logic [31:0] out_addr;
    int          out_lat;
    bit          resp_now;

    initial begin
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        pc_target   = 32'h0;
        tick();
        tick();
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", instr_valid, 1'b0);
        check32("rst_instr", instruction, 32'h0000_0013);
        check32("rst_pc", instr_pc, RST_PC);

        rst = 1'b0;
        settle();
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, RST_PC);

        // Back-to-back stream from RESET_PC.
        fetch_one(32'h100, 32'h1111_0001, 1'b1);
        fetch_one(32'h104, 32'h2222_0002, 1'b1);
        fetch_one(32'h108, 32'h3333_0003, 1'b1);

        // Decode stalls for five cycles.
        fetch_one(32'h10C, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check1("stall_valid", instr_valid, 1'b1);
            check32("stall_instr", instruction, 32'h1234_5678);
            check32("stall_pc", instr_pc, 32'h10C);
            check1("stall_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Redirect while waiting: in-flight 0xDEADBEEF must be discarded.
        imem_gnt = 1'b1;
        settle();
        check32("pre_kill_addr", imem_addr, 32'h110);
        tick();
        imem_gnt  = 1'b0;
        PCSrc     = 1'b1;
        pc_target = 32'h203;
        tick();
        PCSrc       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        settle();
        check1("kill_valid0", instr_valid, 1'b0);
        tick();
        imem_rvalid = 1'b0;
        settle();
        check1("kill_valid1", instr_valid, 1'b0);
        check1("kill_req", imem_req, 1'b1);
        check32("kill_addr", imem_addr, 32'h200);

        // Redirect in the same cycle as the response.
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        PCSrc       = 1'b1;
        pc_target   = 32'h300;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        PCSrc       = 1'b0;
        imem_rvalid = 1'b0;
        settle();
        check1("samecyc_valid", instr_valid, 1'b0);
        check32("samecyc_addr", imem_addr, 32'h300);

        // Redirect wins over a simultaneous handshake.
        fetch_one(32'h300, 32'h0BAD_C0DE, 1'b0);
        PCSrc       = 1'b1;
        pc_target   = 32'h40;
        instr_ready = 1'b1;
        tick();
        PCSrc       = 1'b0;
        instr_ready = 1'b0;
        settle();
        check1("race_valid", instr_valid, 1'b0);
        check1("race_req", imem_req, 1'b1);
        check32("race_addr", imem_addr, 32'h40);

        // Redirect in FETCH with a misaligned target, then pc wrap-around.
        PCSrc     = 1'b1;
        pc_target = 32'hFFFF_FFFF;
        settle();
        check1("fetch_redir_req", imem_req, 1'b0);
        tick();
        PCSrc = 1'b0;
        settle();
        check32("align_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h7777_7777, 1'b1);
        settle();
        check32("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset during WAIT; a late response afterwards must be ignored.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        settle();
        check1("rstwait_req", imem_req, 1'b0);
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        settle();
        check1("late_valid0", instr_valid, 1'b0);
        check1("late_req", imem_req, 1'b1);
        check32("late_addr", imem_addr, RST_PC);
        tick();
        imem_rvalid = 1'b0;
        settle();
        check1("late_valid1", instr_valid, 1'b0);
        check32("late_addr1", imem_addr, RST_PC);

        // Randomized run against the reference queue.
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        exp_q.push_back(RST_PC);
        out_valid = 1'b0;
        out_lat   = 0;
        out_addr  = 32'h0;
        rst       = 1'b0;
        mon_en    = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            resp_now = 1'b0;
            if (out_valid && out_lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(out_addr);
                resp_now    = 1'b1;
            end else if (!out_valid && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1'b1;           // stray response, must be ignored
                imem_rdata  = $urandom;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            PCSrc       = ($urandom_range(0, 9) == 0);
            pc_target   = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            settle();
            if (imem_req) begin
                check1("single_outstanding", out_valid, 1'b0);
            end
            imem_gnt = ($urandom_range(0, 2) != 0);
            if (PCSrc) begin
                exp_q.delete();
                exp_q.push_back({pc_target[31:2], 2'b00});
            end
            if (resp_now) begin
                out_valid = 1'b0;
            end
            if (imem_req && imem_gnt) begin
                out_valid = 1'b1;
                out_addr  = imem_addr;
                out_lat   = $urandom_range(0, 2);
            end else if (out_valid) begin
                out_lat--;
            end
        end
        tick();
        mon_en = 1'b0;
        check1("progress", delivered >= 50, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
